// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan driver.
package seg7_pkg;

    typedef enum logic [0:0] {
        GUARD = 1'b0,
        SHOW  = 1'b1
    } scan_state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
    localparam logic [6:0] SEG_PATTERNS [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic int min_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low 7-segment pattern decoder.
module hex_to_7seg
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Table lookup of the segment pattern for the nibble
    always_comb begin
        seg = SEG_PATTERNS[nibble];
    end

endmodule

// File: rtl/seg7_scan.sv
// N-digit common-anode 7-segment scanner with per-slot ghost-suppression guard.
// Optional macro LEADING_ZERO_BLANK_EN blanks digits above the most-significant nonzero nibble.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int N_DIGITS     = 8,
    parameter int GUARD_CYCLES = 4
) (
    input  logic                    clk_in,
    input  logic                    reset,
    input  logic                    scan_tick,
    input  logic [4*N_DIGITS-1:0]   value,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic [N_DIGITS-1:0]     digit_en,
    output logic [N_DIGITS-1:0]     an,
    output logic [6:0]              seg,
    output logic                    dp
);

    localparam int IDX_W = min_width(N_DIGITS);
    localparam int CNT_W = min_width(GUARD_CYCLES);
    localparam logic [IDX_W-1:0]    IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [CNT_W-1:0]    CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [N_DIGITS-1:0] AN_OFF   = {N_DIGITS{1'b1}};

    scan_state_e            state_r, state_s;
    logic [IDX_W-1:0]       idx_r, idx_s;
    logic [CNT_W-1:0]       cnt_r, cnt_s;

    logic                   latch_s;
    logic [4*N_DIGITS-1:0]  value_sh_r, value_sh_s;
    logic [N_DIGITS-1:0]    dp_sh_r, dp_sh_s;
    logic [N_DIGITS-1:0]    en_sh_r, en_sh_s;

    logic [3:0]             nibble_s;
    logic [6:0]             hex_seg_s;
    logic                   blank_s;

    logic [N_DIGITS-1:0]    an_s, an_r;
    logic [6:0]             seg_s, seg_r;
    logic                   dp_s, dp_r;

    // State, digit index and guard counter registers
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            state_r <= GUARD;
            idx_r   <= IDX_ZERO;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state logic: guard countdown, then hold the digit until the next strobe
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        cnt_s   = cnt_r;
        case (state_r)
            GUARD: begin
                if (cnt_r == CNT_LAST) begin
                    state_s = SHOW;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            SHOW: begin
                if (scan_tick) begin
                    state_s = GUARD;
                    cnt_s   = CNT_ZERO;
                    if (idx_r == IDX_LAST) begin
                        idx_s = IDX_ZERO;
                    end else begin
                        idx_s = idx_r + IDX_W'(1);
                    end
                end else begin
                    state_s = SHOW;
                end
            end
            default: begin
                state_s = GUARD;
                idx_s   = IDX_ZERO;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // Frame latch window: first guard cycle of digit 0 (also the first cycle after reset)
    always_comb begin
        latch_s = (state_r == GUARD) && (idx_r == IDX_ZERO) && (cnt_r == CNT_ZERO);
        if (latch_s) begin
            value_sh_s = value;
            dp_sh_s    = dp_in;
            en_sh_s    = digit_en;
        end else begin
            value_sh_s = value_sh_r;
            dp_sh_s    = dp_sh_r;
            en_sh_s    = en_sh_r;
        end
    end

    // Shadow copies of the displayed frame
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            value_sh_r <= {(4*N_DIGITS){1'b0}};
            dp_sh_r    <= {N_DIGITS{1'b0}};
            en_sh_r    <= {N_DIGITS{1'b0}};
        end else begin
            value_sh_r <= value_sh_s;
            dp_sh_r    <= dp_sh_s;
            en_sh_r    <= en_sh_s;
        end
    end

    // Select the shadow nibble of the upcoming digit
    always_comb begin
        nibble_s = 4'h0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_s == IDX_W'(i)) begin
                nibble_s = value_sh_s[i*4 +: 4];
            end else begin
                nibble_s = nibble_s;
            end
        end
    end

    hex_to_7seg u_hex_to_7seg (
        .nibble (nibble_s),
        .seg    (hex_seg_s)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic [IDX_W-1:0] msd_s;

    // Blank digits above the most-significant nonzero nibble; digit 0 always survives
    always_comb begin
        msd_s = IDX_ZERO;
        for (int i = 1; i < N_DIGITS; i++) begin
            if (value_sh_s[i*4 +: 4] != 4'h0) begin
                msd_s = IDX_W'(i);
            end else begin
                msd_s = msd_s;
            end
        end
        blank_s = (idx_s > msd_s);
    end
`else
    // Every enabled digit is shown, leading zeros included
    always_comb begin
        blank_s = 1'b0;
    end
`endif

    // Output decode from the next state so the pins come straight from flops
    always_comb begin
        an_s  = AN_OFF;
        seg_s = SEG_BLANK;
        dp_s  = 1'b1;
        if (state_s == SHOW) begin
            seg_s = hex_seg_s;
            dp_s  = ~dp_sh_s[idx_s];
            for (int i = 0; i < N_DIGITS; i++) begin
                an_s[i] = ~((idx_s == IDX_W'(i)) && en_sh_s[i] && !blank_s);
            end
        end else begin
            an_s  = AN_OFF;
            seg_s = SEG_BLANK;
            dp_s  = 1'b1;
        end
    end

    // Output registers
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            an_r  <= AN_OFF;
            seg_r <= SEG_BLANK;
            dp_r  <= 1'b1;
        end else begin
            an_r  <= an_s;
            seg_r <= seg_s;
            dp_r  <= dp_s;
        end
    end

    assign an  = an_r;
    assign seg = seg_r;
    assign dp  = dp_r;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed table-driven bench for seg7_scan (N_DIGITS=8, GUARD_CYCLES=4).
module tb_seg7_scan;

    localparam int N = 8;
    localparam int G = 4;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        scan_tick;
    logic [31:0] value;
    logic [7:0]  dp_in;
    logic [7:0]  digit_en;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int checks   = 0;
    int failures = 0;
    int cur      = 0;

    seg7_scan #(.N_DIGITS(N), .GUARD_CYCLES(G)) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .scan_tick (scan_tick),
        .value     (value),
        .dp_in     (dp_in),
        .digit_en  (digit_en),
        .an        (an),
        .seg       (seg),
        .dp        (dp)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [31:0]      value;
        logic [7:0]       dp_in;
        logic [7:0]       en;
        logic [0:7][7:0]  exp_an;
        logic [0:7][6:0]  exp_seg;
        logic [7:0]       exp_dp;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk_in);
        #1;
    endtask

    // One-cycle strobe, guard interval checked, ends with the next digit active
    task automatic advance();
        scan_tick = 1'b1;
        cycle();
        scan_tick = 1'b0;
        check("guard_start_an", {24'h0, an}, 32'hFF);
        repeat (G - 1) cycle();
        check("guard_end_an", {24'h0, an}, 32'hFF);
        cycle();
        cur = (cur + 1) % N;
    endtask

    initial begin
        vecs[0] = '{value: 32'h1234ABCD, dp_in: 8'h00, en: 8'hFF,
                    exp_an: {8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F},
                    exp_seg: {7'h21, 7'h46, 7'h03, 7'h08, 7'h19, 7'h30, 7'h24, 7'h79},
                    exp_dp: 8'hFF};
        vecs[1] = '{value: 32'h12345678, dp_in: 8'h01, en: 8'h0F,
                    exp_an: {8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hFF, 8'hFF, 8'hFF, 8'hFF},
                    exp_seg: {7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79},
                    exp_dp: 8'hFE};
`ifdef LEADING_ZERO_BLANK_EN
        vecs[2] = '{value: 32'h00000050, dp_in: 8'h00, en: 8'hFF,
                    exp_an: {8'hFE, 8'hFD, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF},
                    exp_seg: {7'h40, 7'h12, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40},
                    exp_dp: 8'hFF};
`else
        vecs[2] = '{value: 32'h00000050, dp_in: 8'h00, en: 8'hFF,
                    exp_an: {8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F},
                    exp_seg: {7'h40, 7'h12, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40},
                    exp_dp: 8'hFF};
`endif
        vecs[3] = '{value: 32'hFEDCBA98, dp_in: 8'hAA, en: 8'hFF,
                    exp_an: {8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F},
                    exp_seg: {7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E},
                    exp_dp: 8'h55};
        vecs[4] = '{value: 32'h76543210, dp_in: 8'h80, en: 8'hF0,
                    exp_an: {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hEF, 8'hDF, 8'hBF, 8'h7F},
                    exp_seg: {7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78},
                    exp_dp: 8'h7F};

        reset     = 1'b0;
        scan_tick = 1'b0;
        value     = 32'h0;
        dp_in     = 8'h00;
        digit_en  = 8'hFF;

        // Reset held low, then digit 0 appears on the 4th edge after release
        repeat (5) cycle();
        check("reset_an", {24'h0, an}, 32'hFF);
        check("reset_seg", {25'h0, seg}, 32'h7F);
        check("reset_dp", {31'h0, dp}, 32'h1);
        reset = 1'b1;
        for (int e = 1; e <= G; e++) begin
            cycle();
            if (e < G) begin
                check($sformatf("release_edge%0d_an", e), {24'h0, an}, 32'hFF);
            end else begin
                check("release_an", {24'h0, an}, 32'hFE);
                check("release_seg", {25'h0, seg}, 32'h40);
            end
        end
        cur = 0;
        repeat (N - 1) advance();

        // Table: each vector is applied while digit 7 is shown and latched on the wrap
        for (int v = 0; v < 5; v++) begin
            value    = vecs[v].value;
            dp_in    = vecs[v].dp_in;
            digit_en = vecs[v].en;
            for (int d = 0; d < N; d++) begin
                advance();
                check($sformatf("v%0d_d%0d_an", v, d), {24'h0, an}, {24'h0, vecs[v].exp_an[d]});
                if (vecs[v].exp_an[d] != 8'hFF) begin
                    check($sformatf("v%0d_d%0d_seg", v, d), {25'h0, seg}, {25'h0, vecs[v].exp_seg[d]});
                end else begin
                    check($sformatf("v%0d_d%0d_blank", v, d), {24'h0, an}, 32'hFF);
                end
                check($sformatf("v%0d_d%0d_dp", v, d), {31'h0, dp}, {31'h0, vecs[v].exp_dp[d]});
            end
        end

        // Mid-frame value change must not tear the frame
        value    = 32'h1234ABCD;
        dp_in    = 8'h00;
        digit_en = 8'hFF;
        advance();
        check("tear_d0_seg", {25'h0, seg}, 32'h21);
        repeat (3) advance();
        check("tear_d3_seg", {25'h0, seg}, 32'h08);
        value = 32'hFFFFFFFF;
        advance();
        check("tear_d4_seg", {25'h0, seg}, 32'h19);
        advance();
        check("tear_d5_seg", {25'h0, seg}, 32'h30);
        advance();
        check("tear_d6_seg", {25'h0, seg}, 32'h24);
        advance();
        check("tear_d7_seg", {25'h0, seg}, 32'h79);
        for (int d = 0; d < N; d++) begin
            advance();
            check($sformatf("newframe_d%0d_seg", d), {25'h0, seg}, 32'h0E);
        end

        // scan_tick held for 3 cycles: exactly one advance (7 -> 0)
        scan_tick = 1'b1;
        cycle();
        check("held_t0_an", {24'h0, an}, 32'hFF);
        cycle();
        cycle();
        scan_tick = 1'b0;
        check("held_t2_an", {24'h0, an}, 32'hFF);
        cycle();
        check("held_t3_an", {24'h0, an}, 32'hFF);
        cycle();
        check("held_t4_an", {24'h0, an}, 32'hFE);
        cur = 0;

        // Extra pulse during GUARD is dropped (0 -> 1 only)
        scan_tick = 1'b1;
        cycle();
        scan_tick = 1'b0;
        cycle();
        scan_tick = 1'b1;
        cycle();
        scan_tick = 1'b0;
        cycle();
        check("gpulse_t3_an", {24'h0, an}, 32'hFF);
        cycle();
        check("gpulse_t4_an", {24'h0, an}, 32'hFD);
        cur = 1;
        advance();
        check("gpulse_next_an", {24'h0, an}, 32'hFB);

        // Reset while digit 5 is shown
        repeat (3) advance();
        check("pre_reset_an", {24'h0, an}, 32'hDF);
        value = 32'h00000050;
        reset = 1'b0;
        cycle();
        check("midreset_an", {24'h0, an}, 32'hFF);
        check("midreset_seg", {25'h0, seg}, 32'h7F);
        check("midreset_dp", {31'h0, dp}, 32'h1);
        cycle();
        reset = 1'b1;
        repeat (G - 1) cycle();
        check("restart_guard_an", {24'h0, an}, 32'hFF);
        cycle();
        check("restart_an", {24'h0, an}, 32'hFE);
        check("restart_seg", {25'h0, seg}, 32'h40);
        cur = 0;
        advance();
        check("restart_d1_an", {24'h0, an}, 32'hFD);
        check("restart_d1_seg", {25'h0, seg}, 32'h12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_scan.md
# seg7_scan

Time-multiplexed driver for an N-digit common-anode 7-segment display. It consumes a one-cycle scan strobe from the clock-divider stage and advances one digit per strobe. Each digit slot starts with a ghost-suppression blanking interval. A full value is latched once per frame so the display never tears. It is the stage between the 400 Hz scan-rate divider and the board's anode/cathode pins.

## Interface
- N_DIGITS, 8, number of digits scanned (2..8)
- GUARD_CYCLES, 4, clk_in cycles with all anodes off at each digit change (≥1, < scan_tick period)
- clk_in  input  1  system clock; all logic on its rising edge
- reset  input  1  synchronous, active-low reset
- scan_tick  input  1  one-cycle strobe, advance to next digit
- value  input  4*N_DIGITS  hex nibbles, nibble i shown on digit i (digit 0 = rightmost)
- dp_in  input  N_DIGITS  decimal point request per digit, active-high
- digit_en  input  N_DIGITS  per-digit enable, active-high
- an  output  N_DIGITS  anodes, active-low, one-hot-low or all-high
- seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low
- dp  output  1  decimal point cathode, active-low

## Operation
- States: GUARD (all anodes off, guard counter running), SHOW (anode of current digit driven).
- Reset (reset=0): idx=0, state GUARD, guard count 0, frame latches 0; an=all 1, seg=7'h7F, dp=1.
- GUARD: count increments each clk; at count==GUARD_CYCLES-1 → SHOW. scan_tick in GUARD is dropped.
- SHOW: on scan_tick, idx ← idx+1, wrapping N_DIGITS-1 → 0. Enter GUARD with count 0.
- Frame latch: value, dp_in and digit_en are captured into shadow registers in every cycle with state=GUARD, idx=0, count=0. This covers the first cycle after reset. All display decode uses the shadow copies only.
- Digit with shadow digit_en bit = 0: its slot is still consumed, and an stays all 1. This keeps brightness uniform.
- Decode: 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E (hex, active-low).
- dp = ~shadow_dp[idx] in SHOW, 1 otherwise.

## Timing
- an, seg and dp are registered, decoded from next state. No combinational path from inputs to outputs.
- scan_tick sampled at edge t in SHOW: an=all 1 after edge t. The new digit is active after edge t+GUARD_CYCLES.
- After reset release, digit 0 is active after the GUARD_CYCLES-th rising edge with reset=1.
- New value/dp_in/digit_en take effect at the next digit-0 guard entry. Worst case latency is one full frame.
- Reset asserted mid-frame: outputs reach their reset values on the same edge, and the scan restarts at digit 0.
- scan_tick held high for multiple cycles: one advance, then the rest is ignored during GUARD.

## Configuration
- LEADING_ZERO_BLANK_EN defined: after the frame latch, digits above the most-significant nonzero shadow nibble are forced blank (an all 1 in their slot). Digit 0 is never blanked by this rule. For value=0, only digit 0 shows "0".
- Undefined: every enabled digit is shown, including leading zeros.

## Structure
- seg7_pkg: state enum (GUARD, SHOW), the 16-entry segment pattern constants, SEG_BLANK=7'h7F.
- Sub-module hex_to_7seg: purely combinational, 4-bit in, 7-bit active-low out. It is instantiated once on the selected shadow nibble.
- Leading-zero detection lives in seg7_scan under the macro guard.

## Test plan
- Reset held low 5 cycles → an=8'hFF, seg=7'h7F, dp=1. After release (GUARD_CYCLES=4), an=8'hFE after the 4th edge.
- value=32'h1234ABCD, 8 ticks:
  - an sequence: FE, FD, FB, F7, EF, DF, BF, 7F.
  - seg sequence: 21, 46, 03, 08, 19, 30, 24, 79.
- Change value to 32'hFFFFFFFF while digit 3 is shown → digits 4–7 still show 1234. The next frame shows 0E on all digits.
- digit_en=8'h0F, dp_in=8'h01 → slots 4–7 have an=FF. dp=0 only while digit 0 is shown.
- value=32'h00000050:
  - with LEADING_ZERO_BLANK_EN: digit 0=40, digit 1=12, slots 2–7 an=FF.
  - without it: all 8 digits active, digits 0 and 2–7 show 40.
- scan_tick pulsed during GUARD and held 3 cycles → exactly one advance. Reset asserted while digit 5 is shown → an=FF on that edge, then restart at digit 0.
